// File: rtl/mem_ctrl_sched_pkg.sv
// Shared types and ranking-key layout for the FR-FCFS command scheduler.
package mem_ctrl_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      REFRESH
   } sched_state_e;

   // Slot layout at the default widths; the top uses the same field order.
   typedef struct packed {
      logic [39:0] addr;
      logic [7:0]  id;
      logic [3:0]  len;
      logic        write;
      logic [2:0]  qos;
      logic [6:0]  age;
   } sched_entry_t;

   // Ranking key, MSB first: {aged, hit, qos, age, ~index}.
   function automatic int key_width(int prio_w, int age_w, int idx_w);
      return 2 + prio_w + age_w + idx_w;
   endfunction

endpackage

// File: rtl/mem_ctrl_sched_pick.sv
// Combinational arg-max over per-slot ranking keys.
module mem_ctrl_sched_pick
   import mem_ctrl_sched_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int PRIO_W = 3,
   parameter int AGE_W  = 7
) (
   input  logic [DEPTH-1:0]             valid,
   input  logic [DEPTH-1:0]             aged,
   input  logic [DEPTH-1:0]             hit,
   input  logic [DEPTH-1:0][PRIO_W-1:0] qos,
   input  logic [DEPTH-1:0][AGE_W-1:0]  age,
   output logic [$clog2(DEPTH)-1:0]     win_idx,
   output logic                         found
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int KEY_W = key_width(PRIO_W, AGE_W, IDX_W);

   logic [KEY_W-1:0] keys [DEPTH];
   logic [KEY_W-1:0] best_key;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         keys[i] = {aged[i], hit[i], qos[i], age[i], ~IDX_W'(i)};
      end
   end

   // ~index in the key makes every key unique, so a strict compare suffices.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      best_key = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (!found || keys[i] > best_key)) begin
            found    = 1'b1;
            win_idx  = IDX_W'(i);
            best_key = keys[i];
         end
      end
   end

endmodule

// File: rtl/mem_ctrl_frfcfs_sched.sv
// LPDDR5 FR-FCFS command scheduler: reorder table, bank tracking, refresh FSM.
module mem_ctrl_frfcfs_sched
   import mem_ctrl_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = 40,
   parameter int ID_WIDTH   = 8,
   parameter int DEPTH      = 16,
   parameter int NUM_BANKS  = 16,
   parameter int BANK_LSB   = 6,
   parameter int ROW_LSB    = 12,
   parameter int ROW_WIDTH  = 16,
   parameter int PRIO_WIDTH = 3,
   parameter int AGE_LIMIT  = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     init_done_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [ID_WIDTH-1:0]      req_id_i,
   input  logic                     req_write_i,
   input  logic [3:0]               req_len_i,
   input  logic [PRIO_WIDTH-1:0]    req_qos_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [ADDR_WIDTH-1:0]    out_addr_o,
   output logic [ID_WIDTH-1:0]      out_id_o,
   output logic [3:0]               out_len_o,
   output logic                     out_write_o,
   output logic [PRIO_WIDTH-1:0]    out_prio_o,
   output logic                     out_row_hit_o,
   input  logic                     refresh_req_i,
   output logic                     refresh_ack_o,
   input  logic                     refresh_done_i,
   output logic [$clog2(DEPTH):0]   occupancy_o
);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int AGE_W  = $clog2(AGE_LIMIT + 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [ID_WIDTH-1:0]   id;
      logic [3:0]            len;
      logic                  write;
      logic [PRIO_WIDTH-1:0] qos;
      logic [AGE_W-1:0]      age;
   } entry_t;

   entry_t                         tbl_q [DEPTH];
   logic [DEPTH-1:0]               valid_q;
   logic [NUM_BANKS-1:0]           bank_open_q;
   logic [ROW_WIDTH-1:0]           bank_row_q [NUM_BANKS];
   sched_state_e                   state_q, state_d;

   logic [BANK_W-1:0]              slot_bank [DEPTH];
   logic [ROW_WIDTH-1:0]           slot_row  [DEPTH];
   logic [DEPTH-1:0]               aged, hit;
   logic [DEPTH-1:0][PRIO_WIDTH-1:0] qos;
   logic [DEPTH-1:0][AGE_W-1:0]    age;
   logic [IDX_W-1:0]               win_idx, free_idx;
   logic                           found, load, enq;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_bank[i] = tbl_q[i].addr[BANK_LSB +: BANK_W];
         slot_row[i]  = tbl_q[i].addr[ROW_LSB +: ROW_WIDTH];
         hit[i]       = bank_open_q[slot_bank[i]] &&
                        (bank_row_q[slot_bank[i]] == slot_row[i]);
         aged[i]      = (tbl_q[i].age == AGE_W'(AGE_LIMIT));
         qos[i]       = tbl_q[i].qos;
         age[i]       = tbl_q[i].age;
      end
   end

   always_comb begin
      free_idx    = '0;
      occupancy_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
         occupancy_o = occupancy_o + (IDX_W + 1)'(valid_q[i]);
      end
   end

   mem_ctrl_sched_pick #(
      .DEPTH  (DEPTH),
      .PRIO_W (PRIO_WIDTH),
      .AGE_W  (AGE_W)
   ) u_pick (
      .valid   (valid_q),
      .aged    (aged),
      .hit     (hit),
      .qos     (qos),
      .age     (age),
      .win_idx (win_idx),
      .found   (found)
   );

   // A refresh request pre-empts any load on the same edge.
   assign req_ready_o   = ~&valid_q;
   assign enq           = req_valid_i & req_ready_o;
   assign load          = (state_q == IDLE) & ~refresh_req_i & init_done_i &
                          found & (~out_valid_o | out_ready_i);
   assign refresh_ack_o = (state_q == REFRESH);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (refresh_req_i) state_d = DRAIN;
         DRAIN:   if (!out_valid_o || out_ready_i) state_d = REFRESH;
         REFRESH: if (refresh_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) valid_q[win_idx] <= 1'b0;
         if (enq) valid_q[free_idx] <= 1'b1;
      end
   end

   // Slot payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !(load && win_idx == IDX_W'(i)) && !aged[i])
            tbl_q[i].age <= tbl_q[i].age + 1'b1;
      end
      if (enq) begin
         tbl_q[free_idx] <= '{addr: req_addr_i, id: req_id_i, len: req_len_i,
                              write: req_write_i, qos: req_qos_i, age: '0};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bank_open_q <= '0;
         for (int b = 0; b < NUM_BANKS; b++) bank_row_q[b] <= '0;
      end else if (state_q == REFRESH && refresh_done_i) begin
         bank_open_q <= '0;
      end else if (load) begin
         bank_open_q[slot_bank[win_idx]] <= 1'b1;
         bank_row_q[slot_bank[win_idx]]  <= slot_row[win_idx];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_o   <= 1'b0;
         out_addr_o    <= '0;
         out_id_o      <= '0;
         out_len_o     <= '0;
         out_write_o   <= 1'b0;
         out_prio_o    <= '0;
         out_row_hit_o <= 1'b0;
      end else if (load) begin
         out_valid_o   <= 1'b1;
         out_addr_o    <= tbl_q[win_idx].addr;
         out_id_o      <= tbl_q[win_idx].id;
         out_len_o     <= tbl_q[win_idx].len;
         out_write_o   <= tbl_q[win_idx].write;
         out_prio_o    <= tbl_q[win_idx].qos;
         out_row_hit_o <= hit[win_idx];
      end else if (out_ready_i) begin
         out_valid_o   <= 1'b0;
      end
   end

endmodule

// File: doc/mem_ctrl_frfcfs_sched.md
# mem_ctrl_frfcfs_sched

Parametrised second-generation LPDDR5 command scheduler for the memory-controller datapath. It sits between the per-channel command queue and the DRAM command generator. It holds requests in a slot-based reorder table and issues them with FR-FCFS ordering: aged first, row-hit next, then QoS, then age. Refresh is handled by a drain/refresh/resume FSM, and bank open/row state is tracked per configurable bank count.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- ADDR_WIDTH, 40: request byte-address width.
- ID_WIDTH, 8: transaction ID width.
- DEPTH, 16: table slots; power of two, 2..64.
- NUM_BANKS, 16: power of two, 2..32.
- BANK_LSB, 6: lowest bank-index address bit; bank = addr[BANK_LSB +: log2(NUM_BANKS)].
- ROW_LSB, 12: lowest row address bit.
- ROW_WIDTH, 16: row = addr[ROW_LSB +: ROW_WIDTH].
- PRIO_WIDTH, 3: QoS width; larger value is more urgent.
- AGE_LIMIT, 64: wait cycles after which an entry is forced ahead.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: async active-high reset.
- init_done_i, in, 1: DRAM init complete; issue is blocked while low.
- req_valid_i, in, 1: enqueue request valid.
- req_ready_o, out, 1: a free slot exists.
- req_addr_i, in, ADDR_WIDTH: request address.
- req_id_i, in, ID_WIDTH: request ID.
- req_write_i, in, 1: 1 = write, 0 = read.
- req_len_i, in, 4: burst length.
- req_qos_i, in, PRIO_WIDTH: request priority.
- out_valid_o, out, 1: scheduled command valid.
- out_ready_i, in, 1: downstream accepts the command.
- out_addr_o, out, ADDR_WIDTH: scheduled address.
- out_id_o, out, ID_WIDTH: scheduled ID.
- out_len_o, out, 4: scheduled burst length.
- out_write_o, out, 1: scheduled direction.
- out_prio_o, out, PRIO_WIDTH: scheduled QoS.
- out_row_hit_o, out, 1: command targets the open row of its bank.
- refresh_req_i, in, 1: level refresh request.
- refresh_ack_o, out, 1: high throughout REFRESH state.
- refresh_done_i, in, 1: refresh complete pulse.
- occupancy_o, out, log2(DEPTH)+1: count of valid slots.

## Operation
- **Enqueue:** on req_valid_i & req_ready_o, write the request into the lowest-index invalid slot and clear its age. Enqueue is permitted in every FSM state and while init_done_i is low.
- **Aging:**
  - Each valid slot's age counter increments every cycle it is not selected.
  - The counter saturates at AGE_LIMIT and is log2(AGE_LIMIT+1) bits wide.
  - A slot is "aged" when age == AGE_LIMIT.
- **Selection:** combinational over valid slots.
  - Rank order: aged > row-hit > higher QoS > larger age > lower slot index.
  - A slot is a row hit when bank_open[bank] is set and bank_row[bank] equals the slot's row.
- **Load:** when the FSM is IDLE, init_done_i=1, a candidate exists, and (!out_valid_o or out_ready_i), the winner loads into the output register. On the same edge:
  - its slot is freed;
  - out_row_hit_o is captured;
  - bank_open[bank] is set and bank_row[bank] is set to the winner's row.
- **Output register:** holds stable while out_valid_o & !out_ready_i. out_valid_o clears on acceptance unless a new load occurs on the same edge.
- **FSM:**
  - IDLE → DRAIN when refresh_req_i=1. Loads stop immediately.
  - DRAIN → REFRESH when out_valid_o=0, or on the edge where the held command is accepted.
  - In REFRESH, refresh_ack_o=1. On refresh_done_i all bank_open bits clear and the FSM returns to IDLE.
  - refresh_req_i is ignored outside IDLE.

## Timing
- Reset values:
  - out_valid_o, refresh_ack_o, out_row_hit_o, all out_* fields, and occupancy_o are 0.
  - req_ready_o=1.
  - FSM is IDLE; all banks are closed.
- Latency: a request accepted at edge t becomes a valid slot after t. The earliest load is at edge t+1, so out_valid_o rises in the cycle after t+1 (two cycles, fill to issue).
- Throughput: one command per cycle under continuous out_ready_i.
- req_ready_o is computed from registered valid bits only. A slot freed on edge t is reusable from the cycle after t; when the table is full and a slot issues in cycle c, req_ready_o stays 0 in c.
- Simultaneous enqueue and load on the same edge: occupancy is unchanged, and the freed and filled slots are different.
- Simultaneous refresh_req_i and load-eligible in IDLE: refresh wins, and no load happens on that edge.
- Reset mid-operation clears all slots; in-flight commands are lost.

## Structure
- Package mem_ctrl_sched_pkg:
  - sched_state_e (IDLE, DRAIN, REFRESH);
  - sched_entry_t struct (addr, id, len, write, qos, age);
  - the ranking-key concatenation order.
- Sub-module mem_ctrl_sched_pick: parameterised combinational arg-max over DEPTH ranking keys {aged, hit, qos, age, ~index}. It returns winner index and found.

## Test plan
- Four reads, all qos=0, addrs hitting bank 0 at rows 5,7,5,5; row 5 open → issue order is slots 0,2,3, then the row-7 read last; out_row_hit_o=1 for the first three and 0 for the last.
- Requests qos=1 then qos=6 to different closed banks → qos=6 issues first; out_prio_o=6.
- A qos=0 row-miss request waits while AGE_LIMIT=64 hit requests stream in with out_ready_i=1 → the miss issues no later than 65 cycles after its enqueue.
- Fill DEPTH=16 with out_ready_i=0 → req_ready_o=0 and occupancy_o=16; release one → req_ready_o=1 one cycle later.
- Command held with out_ready_i=0, assert refresh_req_i → no new load; refresh_ack_o rises only after acceptance; on refresh_done_i banks close and the next command has out_row_hit_o=0.
- Assert rst_i with 5 entries queued → all outputs return to reset values asynchronously; occupancy_o=0.
